sram_bus_arbiter: RTL and testbench

- Arbitrates the IF-stage instruction port and the MEM-stage data port onto the two off-chip asynchronous SRAMs: BaseRAM and ExtRAM.
- Sits directly downstream of the core pipeline in mycpu_top.
- Converts single-request/done-pulse handshakes into registered SRAM pin timing, including tri-state data buses.
- Serializes accesses: one outstanding transaction at a time, data port has priority.

---
 rtl/sram_bus_pkg.sv | 39 +++
 rtl/sram_pin_driver.sv | 57 +++++
 rtl/sram_bus_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_sram_bus_arbiter.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_bus_pkg.sv
// Shared types and address decode for the SRAM bus arbiter: FSM states,
// memory targets, requester ids and the 4 MB window compare.
package sram_bus_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_DONE
    } state_t;

    typedef enum logic [1:0] {
        TGT_NONE,
        TGT_BASE,
        TGT_EXT
    } target_t;

    typedef enum logic {
        PORT_INST,
        PORT_DATA
    } port_t;

    localparam logic [31:0] BASE_LO_DEFAULT = 32'h8000_0000;
    localparam logic [31:0] EXT_LO_DEFAULT  = 32'h8040_0000;
    localparam int          WORD_AW         = 20;

    // Windows are 4 MB, so only the top ten address bits pick the device.
    function automatic target_t decode_target(input logic [9:0] region,
                                              input logic [9:0] base_region,
                                              input logic [9:0] ext_region);
        if (region == base_region) begin
            return TGT_BASE;
        end
        if (region == ext_region) begin
            return TGT_EXT;
        end
        return TGT_NONE;
    endfunction

endpackage

// File: rtl/sram_pin_driver.sv
// Registered pin stage for one asynchronous SRAM: strobes, address, byte
// enables and a tri-state write-data driver; read data is passed straight back.
module sram_pin_driver
    import sram_bus_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               ce_d,
    input  logic               oe_d,
    input  logic               we_d,
    input  logic               drive_d,
    input  logic [WORD_AW-1:0] addr_d,
    input  logic [3:0]         be_n_d,
    input  logic [31:0]        wdata_d,
    inout  wire  [31:0]        ram_data,
    output logic [WORD_AW-1:0] ram_addr,
    output logic [3:0]         ram_be_n,
    output logic               ram_ce_n,
    output logic               ram_oe_n,
    output logic               ram_we_n,
    output logic [31:0]        rd_data
);

    logic        drive_q;
    logic [31:0] wdata_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            ram_ce_n <= 1'b1;
            ram_oe_n <= 1'b1;
            ram_we_n <= 1'b1;
            ram_be_n <= 4'hF;
            ram_addr <= '0;
            drive_q  <= 1'b0;
        end else begin
            ram_ce_n <= ~ce_d;
            ram_oe_n <= ~oe_d;
            ram_we_n <= ~we_d;
            ram_be_n <= be_n_d;
            drive_q  <= drive_d;
            // Address is left parked on the last access between transactions.
            if (ce_d) begin
                ram_addr <= addr_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (drive_d) begin
            wdata_q <= wdata_d;
        end
    end

    assign ram_data = drive_q ? wdata_q : 'z;
    assign rd_data  = ram_data;

endmodule

// File: rtl/sram_bus_arbiter.sv
// Serializes the IF instruction port and MEM data port onto BaseRAM/ExtRAM,
// one transaction at a time with the data port taking priority.
module sram_bus_arbiter
    import sram_bus_pkg::*;
#(
    parameter int          WAIT_CYCLES = 1,
    parameter logic [31:0] BASE_LO     = BASE_LO_DEFAULT,
    parameter logic [31:0] EXT_LO      = EXT_LO_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_sram_en,
    input  logic [31:0] inst_sram_addr,
    output logic [31:0] inst_sram_rdata,
    output logic        is_if_read,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_we,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    output logic        is_mem_read,
    inout  wire  [31:0] base_ram_data,
    output logic [19:0] base_ram_addr,
    output logic [3:0]  base_ram_be_n,
    output logic        base_ram_ce_n,
    output logic        base_ram_oe_n,
    output logic        base_ram_we_n,
    inout  wire  [31:0] ext_ram_data,
    output logic [19:0] ext_ram_addr,
    output logic [3:0]  ext_ram_be_n,
    output logic        ext_ram_ce_n,
    output logic        ext_ram_oe_n,
    output logic        ext_ram_we_n
);

    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    port_t              port_q, port_d;
    target_t            tgt_q, tgt_d;
    logic [WORD_AW-1:0] addr_q, addr_d;
    logic [3:0]         we_q, we_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [31:0]        req_addr;
    logic               capture, zero_read;
    logic [31:0]        cap_data;
    logic [31:0]        base_rd, ext_rd;
    logic               unused_addr_bits;

    assign unused_addr_bits = ^req_addr[1:0];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        port_d    = port_q;
        tgt_d     = tgt_q;
        addr_d    = addr_q;
        we_d      = we_q;
        wdata_d   = wdata_q;
        req_addr  = inst_sram_addr;
        capture   = 1'b0;
        zero_read = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (data_sram_en || inst_sram_en) begin
                    port_d   = data_sram_en ? PORT_DATA : PORT_INST;
                    req_addr = data_sram_en ? data_sram_addr : inst_sram_addr;
                    tgt_d    = decode_target(req_addr[31:22], BASE_LO[31:22], EXT_LO[31:22]);
                    addr_d   = req_addr[21:2];
                    we_d     = data_sram_en ? data_sram_we : 4'h0;
                    wdata_d  = data_sram_wdata;
                    if (tgt_d == TGT_NONE) begin
                        // Unmapped: no pin activity, reads complete with zero.
                        state_d   = S_DONE;
                        zero_read = (we_d == 4'h0);
                    end else begin
                        state_d = S_ACCESS;
                        cnt_d   = CNT_W'(WAIT_CYCLES - 1);
                    end
                end
            end
            S_ACCESS: begin
                if (cnt_q == '0) begin
                    state_d = S_DONE;
                    capture = (we_q == 4'h0);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        cap_data = '0;
        if (capture) begin
            cap_data = (tgt_q == TGT_BASE) ? base_rd : ext_rd;
        end
    end

    // Next-cycle pin intent; the pin drivers register it so the SRAM sees clean edges.
    logic       is_wr_d, active_d, hold_d;
    logic       base_ce_d, ext_ce_d;
    logic [3:0] be_n_act;

    always_comb begin
        is_wr_d   = |we_d;
        active_d  = (state_d == S_ACCESS);
        hold_d    = (state_d == S_DONE) && is_wr_d;
        base_ce_d = (tgt_d == TGT_BASE) && (active_d || hold_d);
        ext_ce_d  = (tgt_d == TGT_EXT) && (active_d || hold_d);
        be_n_act  = is_wr_d ? ~we_d : 4'h0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= S_IDLE;
            cnt_q           <= '0;
            is_if_read      <= 1'b0;
            is_mem_read     <= 1'b0;
            inst_sram_rdata <= '0;
            data_sram_rdata <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            is_if_read  <= (state_d == S_DONE) && (port_d == PORT_INST);
            is_mem_read <= (state_d == S_DONE) && (port_d == PORT_DATA);
            if (capture || zero_read) begin
                if (port_d == PORT_DATA) begin
                    data_sram_rdata <= cap_data;
                end else begin
                    inst_sram_rdata <= cap_data;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        port_q  <= port_d;
        tgt_q   <= tgt_d;
        addr_q  <= addr_d;
        we_q    <= we_d;
        wdata_q <= wdata_d;
    end

    sram_pin_driver u_base (
        .clk      (clk),
        .reset    (reset),
        .ce_d     (base_ce_d),
        .oe_d     (base_ce_d && active_d && !is_wr_d),
        .we_d     (base_ce_d && active_d && is_wr_d),
        .drive_d  (base_ce_d && is_wr_d),
        .addr_d   (addr_d),
        .be_n_d   (base_ce_d ? be_n_act : 4'hF),
        .wdata_d  (wdata_d),
        .ram_data (base_ram_data),
        .ram_addr (base_ram_addr),
        .ram_be_n (base_ram_be_n),
        .ram_ce_n (base_ram_ce_n),
        .ram_oe_n (base_ram_oe_n),
        .ram_we_n (base_ram_we_n),
        .rd_data  (base_rd)
    );

    sram_pin_driver u_ext (
        .clk      (clk),
        .reset    (reset),
        .ce_d     (ext_ce_d),
        .oe_d     (ext_ce_d && active_d && !is_wr_d),
        .we_d     (ext_ce_d && active_d && is_wr_d),
        .drive_d  (ext_ce_d && is_wr_d),
        .addr_d   (addr_d),
        .be_n_d   (ext_ce_d ? be_n_act : 4'hF),
        .wdata_d  (wdata_d),
        .ram_data (ext_ram_data),
        .ram_addr (ext_ram_addr),
        .ram_be_n (ext_ram_be_n),
        .ram_ce_n (ext_ram_ce_n),
        .ram_oe_n (ext_ram_oe_n),
        .ram_we_n (ext_ram_we_n),
        .rd_data  (ext_rd)
    );

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Bench for sram_bus_arbiter: SRAM pin models, a word-level reference memory,
// a done-pulse scoreboard, directed cases and randomized two-port traffic.
module tb_sram_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        inst_en = 1'b0;
    logic [31:0] inst_addr = '0;
    logic [31:0] inst_rdata;
    logic        is_if;
    logic        data_en = 1'b0;
    logic [3:0]  data_we = '0;
    logic [31:0] data_addr = '0;
    logic [31:0] data_wdata = '0;
    logic [31:0] data_rdata;
    logic        is_mem;
    wire  [31:0] base_data, ext_data;
    logic [19:0] base_addr, ext_addr;
    logic [3:0]  base_be_n, ext_be_n;
    logic        base_ce_n, base_oe_n, base_we_n;
    logic        ext_ce_n, ext_oe_n, ext_we_n;

    // Second instance with a longer strobe, instruction reads only.
    logic        inst3_en = 1'b0;
    logic [31:0] inst3_addr = '0;
    logic [31:0] inst3_rdata;
    logic        is_if3;
    logic        d3_en = 1'b0;
    logic [3:0]  d3_we = '0;
    logic [31:0] d3_addr = '0;
    logic [31:0] d3_wdata = '0;
    logic [31:0] unused_d3_rdata;
    logic        unused_d3_done;
    wire  [31:0] b3_data;
    logic [19:0] b3_addr;
    logic [3:0]  unused_b3_be_n;
    logic        b3_ce_n, b3_oe_n, b3_we_n;
    wire  [31:0] unused_ext3_data;
    logic [19:0] unused_ext3_addr;
    logic [3:0]  unused_ext3_be_n;
    logic        unused_ext3_ce_n, unused_ext3_oe_n, unused_ext3_we_n;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    sram_bus_arbiter #(.WAIT_CYCLES(1)) dut (
        .clk(clk), .reset(reset),
        .inst_sram_en(inst_en), .inst_sram_addr(inst_addr),
        .inst_sram_rdata(inst_rdata), .is_if_read(is_if),
        .data_sram_en(data_en), .data_sram_we(data_we), .data_sram_addr(data_addr),
        .data_sram_wdata(data_wdata), .data_sram_rdata(data_rdata), .is_mem_read(is_mem),
        .base_ram_data(base_data), .base_ram_addr(base_addr), .base_ram_be_n(base_be_n),
        .base_ram_ce_n(base_ce_n), .base_ram_oe_n(base_oe_n), .base_ram_we_n(base_we_n),
        .ext_ram_data(ext_data), .ext_ram_addr(ext_addr), .ext_ram_be_n(ext_be_n),
        .ext_ram_ce_n(ext_ce_n), .ext_ram_oe_n(ext_oe_n), .ext_ram_we_n(ext_we_n)
    );

    sram_bus_arbiter #(.WAIT_CYCLES(3)) dut3 (
        .clk(clk), .reset(reset),
        .inst_sram_en(inst3_en), .inst_sram_addr(inst3_addr),
        .inst_sram_rdata(inst3_rdata), .is_if_read(is_if3),
        .data_sram_en(d3_en), .data_sram_we(d3_we), .data_sram_addr(d3_addr),
        .data_sram_wdata(d3_wdata), .data_sram_rdata(unused_d3_rdata), .is_mem_read(unused_d3_done),
        .base_ram_data(b3_data), .base_ram_addr(b3_addr), .base_ram_be_n(unused_b3_be_n),
        .base_ram_ce_n(b3_ce_n), .base_ram_oe_n(b3_oe_n), .base_ram_we_n(b3_we_n),
        .ext_ram_data(unused_ext3_data), .ext_ram_addr(unused_ext3_addr), .ext_ram_be_n(unused_ext3_be_n),
        .ext_ram_ce_n(unused_ext3_ce_n), .ext_ram_oe_n(unused_ext3_oe_n), .ext_ram_we_n(unused_ext3_we_n)
    );

    function automatic logic [31:0] init_word(input int ram, input int idx);
        if (ram == 0 && idx == 4) return 32'h1234_5678;
        return (32'(idx) * 32'h0100_0193) ^ ((ram == 0) ? 32'h5A5A_0000 : 32'hA5A5_00FF);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Pin-level asynchronous SRAM models (1K words each, reloaded on reset).
    logic [31:0] base_mem [1024];
    logic [31:0] ext_mem  [1024];

    assign base_data = (!base_ce_n && !base_oe_n && base_we_n) ? base_mem[base_addr[9:0]] : 'z;
    assign ext_data  = (!ext_ce_n && !ext_oe_n && ext_we_n) ? ext_mem[ext_addr[9:0]] : 'z;
    assign b3_data   = (!b3_ce_n && !b3_oe_n) ? init_word(0, int'(b3_addr[9:0])) : 'z;

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 1024; i++) begin
                base_mem[i] <= init_word(0, i);
                ext_mem[i]  <= init_word(1, i);
            end
        end else begin
            for (int b = 0; b < 4; b++) begin
                if (!base_ce_n && !base_we_n && !base_be_n[b])
                    base_mem[base_addr[9:0]][8*b +: 8] <= base_data[8*b +: 8];
                if (!ext_ce_n && !ext_we_n && !ext_be_n[b])
                    ext_mem[ext_addr[9:0]][8*b +: 8] <= ext_data[8*b +: 8];
            end
        end
    end

    // Word-level reference memory and scoreboard queues.
    logic [31:0] ref_base [1024];
    logic [31:0] ref_ext  [1024];
    logic [31:0] exp_inst [$];
    logic [31:0] exp_data [$];
    logic [31:0] last_drd = '0;

    task automatic ref_init();
        for (int i = 0; i < 1024; i++) begin
            ref_base[i] = init_word(0, i);
            ref_ext[i]  = init_word(1, i);
        end
        last_drd = '0;
    endtask

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        if (a[31:22] == 10'h200) return ref_base[a[11:2]];
        if (a[31:22] == 10'h201) return ref_ext[a[11:2]];
        return 32'h0;
    endfunction

    task automatic ref_write(input logic [31:0] a, input logic [3:0] we, input logic [31:0] wd);
        for (int b = 0; b < 4; b++) begin
            if (we[b] && a[31:22] == 10'h200) ref_base[a[11:2]][8*b +: 8] = wd[8*b +: 8];
            if (we[b] && a[31:22] == 10'h201) ref_ext[a[11:2]][8*b +: 8] = wd[8*b +: 8];
        end
    endtask

    // Monitor: scoreboard pops on done pulses, pin recording and protocol checks.
    int          base_oe_cyc = 0, ext_we_cyc = 0, strobe_cyc = 0, b3_oe_cyc = 0;
    logic [19:0] rec_base_addr = '0, rec_ext_addr = '0;
    logic [3:0]  rec_ext_be_n = '0;
    logic [31:0] rec_ext_hold = '0;

    always @(negedge clk) begin
        if (!reset) begin
            if (is_mem) begin
                if (exp_data.size() == 0) chk("spurious is_mem_read", 32'd1, 32'd0);
                else chk("data_sram_rdata", data_rdata, exp_data.pop_front());
            end
            if (is_if) begin
                if (exp_inst.size() == 0) chk("spurious is_if_read", 32'd1, 32'd0);
                else chk("inst_sram_rdata", inst_rdata, exp_inst.pop_front());
            end
            base_oe_cyc += int'(!base_oe_n);
            ext_we_cyc  += int'(!ext_we_n);
            b3_oe_cyc   += int'(!b3_oe_n);
            if (!base_ce_n || !ext_ce_n || !base_oe_n || !ext_oe_n || !base_we_n || !ext_we_n)
                strobe_cyc++;
            if (!base_ce_n) rec_base_addr = base_addr;
            if (!ext_ce_n && !ext_we_n) begin
                rec_ext_addr = ext_addr;
                rec_ext_be_n = ext_be_n;
            end
            if (!ext_ce_n && ext_we_n && ext_oe_n) rec_ext_hold = ext_data;
            if (!base_ce_n || !ext_ce_n)
                chk("pin overlap/strobe conflict",
                    32'({!base_ce_n && !ext_ce_n, !base_oe_n && !base_we_n, !ext_oe_n && !ext_we_n}), 32'd0);
            if (!b3_ce_n) chk("w3 we_n during read", 32'(b3_we_n), 32'd1);
        end
    end

    // One requester transaction; call at a negedge, returns at the done negedge.
    task automatic port_txn(input bit is_data, input logic [3:0] we, input logic [31:0] addr,
                            input logic [31:0] wdata, input bit scramble, output int lat);
        if (is_data) begin
            if (we == 4'h0) begin
                last_drd = ref_read(addr);
            end else begin
                ref_write(addr, we, wdata);
            end
            exp_data.push_back(last_drd);
            data_en = 1'b1; data_we = we; data_addr = addr; data_wdata = wdata;
        end else begin
            exp_inst.push_back(ref_read(addr));
            inst_en = 1'b1; inst_addr = addr;
        end
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (is_data ? is_mem : is_if) begin
                lat = n;
                break;
            end
            if (scramble && is_data) data_wdata = $urandom;
        end
        if (is_data) data_en = 1'b0; else inst_en = 1'b0;
        if (lat < 0) chk(is_data ? "data done timeout" : "inst done timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int lat, lat_i, s0, s1;
        logic [31:0] w, a;
        logic [3:0]  we;

        ref_init();
        repeat (3) @(negedge clk);
        chk("reset base_ce_n", 32'(base_ce_n), 32'd1);
        chk("reset base_oe_n", 32'(base_oe_n), 32'd1);
        chk("reset ext_we_n", 32'(ext_we_n), 32'd1);
        chk("reset base_be_n", 32'(base_be_n), 32'hF);
        chk("reset ext_addr", 32'(ext_addr), 32'd0);
        chk("reset data_rdata", data_rdata, 32'd0);
        chk("reset inst_rdata", inst_rdata, 32'd0);
        chk("reset done pulses", 32'({is_if, is_mem}), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Instruction read from BaseRAM word 4.
        s0 = base_oe_cyc;
        port_txn(1'b0, 4'h0, 32'h8000_0010, 32'h0, 1'b0, lat);
        chk("inst read latency", 32'(lat), 32'd2);
        chk("inst read rdata", inst_rdata, 32'h1234_5678);
        @(negedge clk);
        chk("inst read base_addr", 32'(rec_base_addr), 32'd4);
        chk("inst read oe cycles", 32'(base_oe_cyc - s0), 32'd1);

        // Partial data write to ExtRAM word 2 with inputs scrambled mid-access.
        s0 = ext_we_cyc;
        port_txn(1'b1, 4'b0011, 32'h8040_0008, 32'hDEAD_BEEF, 1'b1, lat);
        chk("write latency", 32'(lat), 32'd2);
        @(negedge clk);
        chk("write ext_addr", 32'(rec_ext_addr), 32'd2);
        chk("write ext_be_n", 32'(rec_ext_be_n), 32'hC);
        chk("write we cycles", 32'(ext_we_cyc - s0), 32'd1);
        chk("write data hold", rec_ext_hold, 32'hDEAD_BEEF);
        w = init_word(1, 2);
        chk("write sram word", ext_mem[2], {w[31:16], 16'hBEEF});

        // Simultaneous requests: data wins, instruction follows.
        fork
            port_txn(1'b1, 4'h0, 32'h8000_0004, 32'h0, 1'b0, lat);
            port_txn(1'b0, 4'h0, 32'h8000_0000, 32'h0, 1'b0, lat_i);
        join
        chk("simul data latency", 32'(lat), 32'd2);
        chk("simul inst latency", 32'(lat_i), 32'd5);
        chk("simul inst rdata", inst_rdata, init_word(0, 0));
        @(negedge clk);

        // Unmapped data read.
        s0 = strobe_cyc;
        port_txn(1'b1, 4'h0, 32'h1FD0_03F8, 32'h0, 1'b0, lat);
        chk("unmapped latency", 32'(lat), 32'd1);
        chk("unmapped rdata", data_rdata, 32'h0);
        chk("unmapped strobes", 32'(strobe_cyc - s0), 32'd0);
        @(negedge clk);

        // Longer strobe instance.
        s1 = b3_oe_cyc;
        inst3_en = 1'b1; inst3_addr = 32'h8000_0000 + 32'd148;
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (is_if3) begin
                lat = n;
                break;
            end
        end
        inst3_en = 1'b0;
        chk("w3 latency", 32'(lat), 32'd4);
        chk("w3 rdata", inst3_rdata, init_word(0, 37));
        @(negedge clk);
        chk("w3 oe cycles", 32'(b3_oe_cyc - s1), 32'd3);

        // Randomized concurrent traffic on both ports.
        fork
            begin
                int l;
                for (int k = 0; k < 40; k++) begin
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                    port_txn(1'b0, 4'h0, 32'h8000_0000 | (32'($urandom_range(0, 127)) << 2), 32'h0, 1'b0, l);
                end
            end
            begin
                int l;
                logic [31:0] ra;
                for (int k = 0; k < 40; k++) begin
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                    case ($urandom_range(0, 4))
                        0, 1:    ra = 32'h8000_0000 | (32'($urandom_range(128, 1023)) << 2);
                        2, 3:    ra = 32'h8040_0000 | (32'($urandom_range(0, 1023)) << 2);
                        default: ra = 32'h1FC0_0000 | ($urandom & 32'h003F_FFFC);
                    endcase
                    port_txn(1'b1, ($urandom_range(0, 1) != 0) ? 4'($urandom_range(1, 15)) : 4'h0,
                             ra, $urandom, 1'b0, l);
                end
            end
        join
        repeat (2) @(negedge clk);
        chk("scoreboard drained", 32'(exp_data.size() + exp_inst.size()), 32'd0);

        // Reset during the access phase of a write.
        data_en = 1'b1; data_we = 4'hF; data_addr = 32'h8040_0100; data_wdata = 32'hCAFE_F00D;
        @(negedge clk);
        chk("rst-mid write underway", 32'(ext_we_n), 32'd0);
        reset = 1'b1; data_en = 1'b0;
        @(negedge clk);
        chk("rst-mid we_n", 32'(ext_we_n), 32'd1);
        chk("rst-mid ce_n", 32'(ext_ce_n), 32'd1);
        chk("rst-mid no done", 32'(is_mem), 32'd0);
        reset = 1'b0;
        ref_init();
        @(negedge clk);
        chk("post-rst no done", 32'(is_mem), 32'd0);
        chk("post-rst rdata", data_rdata, 32'd0);
        a = 32'h8040_0100; we = 4'h0;
        port_txn(1'b1, we, a, 32'h0, 1'b0, lat);
        chk("post-rst read latency", 32'(lat), 32'd2);
        chk("post-rst read rdata", data_rdata, init_word(1, 64));
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
